// File: rtl/sc1_loader_pkg.sv
// sc1_loader_pkg: frame sync constant and loader FSM state encoding shared by the loader files
package sc1_loader_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'h5C;
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERROR} state_t;
endpackage

// File: rtl/rw_port_ram.sv
// rw_port_ram: one write port plus one registered read port; a same-address read returns the old word
module rw_port_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  // Array has no reset so a reset leaves the loaded program intact.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge reset)
    if (!reset) rdata <= '0;
    else rdata <= mem[raddr];
endmodule

// File: rtl/sc1_loader.sv
// sc1_loader: receives a sync/length/data/checksum byte frame into program RAM and gates the CPU reset
module sc1_loader
  import sc1_loader_pkg::*;
#(
  parameter int WIDTH_I = 32,
  parameter int DEPTH_I = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic [DEPTH_I-1:0] rom_addr,
  output logic [WIDTH_I-1:0] rom_data,
  output logic               cpu_reset,
  output logic               load_done,
  output logic               load_error
);
  state_t             state;
  logic [7:0]         len;
  logic [7:0]         csum;
  logic [7:0]         word_idx;
  logic [1:0]         byte_cnt;
  logic [DEPTH_I-1:0] addr;
  logic [23:0]        asm_q;
  logic [WIDTH_I-1:0] wr_data;
  logic               wr_en;
  logic               acc;
  logic               csum_ok;
  assign rx_ready = reset;
  assign acc      = rx_valid & rx_ready;
  assign csum_ok  = rx_data == csum;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      len        <= '0;
      csum       <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      addr       <= '0;
      asm_q      <= '0;
      wr_data    <= '0;
      wr_en      <= 1'b0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (wr_en) addr <= addr + 1'b1;
      if (acc)
        case (state)
          IDLE: if (rx_data == SYNC_BYTE) state <= LEN;
          LEN: begin
            len      <= rx_data;
            addr     <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
            csum     <= '0;
            state    <= DATA;
          end
          DATA: begin
            // Shifting in from the top leaves the first byte of a word in [7:0] once three bytes are in.
            csum     <= csum + rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            asm_q    <= {rx_data, asm_q[23:8]};
            if (byte_cnt == 2'd3) begin
              wr_data  <= {rx_data, asm_q};
              wr_en    <= 1'b1;
              word_idx <= word_idx + 8'd1;
              if (word_idx == len) state <= CSUM;
            end
          end
          CSUM: begin
            state      <= csum_ok ? DONE : ERROR;
            load_done  <= csum_ok;
            load_error <= !csum_ok;
            cpu_reset  <= !csum_ok;
          end
          default:
            if (rx_data == SYNC_BYTE) begin
              state      <= LEN;
              cpu_reset  <= 1'b1;
              load_done  <= 1'b0;
              load_error <= 1'b0;
            end
        endcase
    end
  rw_port_ram #(.DATA_WIDTH(WIDTH_I), .ADDR_WIDTH(DEPTH_I)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr (addr),
    .wdata (wr_data),
    .raddr (rom_addr),
    .rdata (rom_data)
  );
endmodule

// File: tb/tb_sc1_loader.sv
// tb_sc1_loader: directed and randomized frames checked against a word-array model of the program RAM
module tb_sc1_loader;
  typedef logic [7:0] u8;
  typedef u8 bq_t[$];
  logic        clk = 0, reset = 1, rx_valid = 0;
  logic        rx_ready, cpu_reset, load_done, load_error;
  logic [7:0]  rx_data = 0, rom_addr = 0;
  logic [31:0] rom_data;
  int          checks = 0, errors = 0;
  logic [31:0] mdl [256];
  logic        exp_done = 0, exp_err = 0, exp_cpu = 1;
  u8           q[$];

  sc1_loader dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic status_chk(input string tag);
    chk({tag, "_done"}, load_done, exp_done);
    chk({tag, "_err"}, load_error, exp_err);
    chk({tag, "_cpu"}, cpu_reset, exp_cpu);
  endtask

  task automatic send_byte(input u8 b);
    @(negedge clk);
    rx_valid = 1;
    rx_data  = b;
    @(posedge clk);
    #1 rx_valid = 0;
    rx_data = u8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_data = u8'($urandom);
      @(posedge clk);
    end
  endtask

  function automatic bq_t seq(input u8 first, input u8 step, input int n);
    bq_t r;
    for (int i = 0; i < n; i++) r.push_back(u8'(first + step * i));
    return r;
  endfunction

  function automatic bq_t rnd_bytes(input int n);
    bq_t r;
    for (int i = 0; i < n; i++) r.push_back(u8'($urandom));
    return r;
  endfunction

  // Model: a load writes word w = bytes 4w..4w+3 little-endian at w mod 256; checksum is the byte sum.
  task automatic make_frame(input u8 len, input bq_t dq, input u8 delta);
    u8 sum = 0;
    q.delete();
    q.push_back(8'h5C);
    q.push_back(len);
    foreach (dq[i]) begin
      q.push_back(dq[i]);
      sum += dq[i];
    end
    for (int w = 0; w <= int'(len); w++)
      mdl[w % 256] = {dq[4*w+3], dq[4*w+2], dq[4*w+1], dq[4*w]};
    q.push_back(u8'(sum + delta));
    exp_done = delta == 0;
    exp_err  = delta != 0;
    exp_cpu  = delta != 0;
  endtask

  task automatic send_frame(input int mode);
    for (int i = 0; i < q.size() - 1; i++) begin
      send_byte(q[i]);
      if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) idle(mode == 1 ? 1 : $urandom_range(1, 2));
    end
    chk("inflight_done", load_done, 1'b0);
    chk("inflight_err", load_error, 1'b0);
    chk("inflight_cpu", cpu_reset, 1'b1);
    send_byte(q[q.size() - 1]);
    status_chk("frame");
  endtask

  task automatic read_chk(input int a);
    @(negedge clk);
    rom_addr = u8'(a);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("rom[%0d]", a), rom_data, mdl[a]);
  endtask

  initial begin
    #1 reset = 0;
    #10;
    chk("rst_cpu", cpu_reset, 1'b1);
    chk("rst_done", load_done, 1'b0);
    chk("rst_err", load_error, 1'b0);
    chk("rst_ready", rx_ready, 1'b0);
    chk("rst_rom", rom_data, 32'h0);
    @(negedge clk);
    reset = 1;
    #1 chk("ready_up", rx_ready, 1'b1);
    // Basic frame preceded by junk, exact spec checksum 0x64.
    send_byte(8'h00);
    send_byte(8'hFF);
    status_chk("junk");
    make_frame(8'd1, seq(8'h11, 8'h11, 8), 8'd0);
    send_frame(0);
    read_chk(0);
    chk("w0_spec", rom_data, 32'h44332211);
    @(negedge clk);
    rom_addr = 1;
    #1 chk("latency_old", rom_data, 32'h44332211);
    @(posedge clk);
    @(negedge clk);
    chk("w1_spec", rom_data, 32'h88776655);
    // Bad checksum 0x65 then a good frame.
    make_frame(8'd1, seq(8'h11, 8'h11, 8), 8'd1);
    send_frame(0);
    make_frame(8'd1, seq(8'h11, 8'h11, 8), 8'd0);
    send_frame(0);
    // Reload after DONE with L=0, watching the write/read collision on word 0.
    make_frame(8'd0, seq(8'hAA, 8'h11, 4), 8'd0);
    @(negedge clk);
    rom_addr = 0;
    send_byte(q[0]);
    chk("resync_cpu", cpu_reset, 1'b1);
    chk("resync_done", load_done, 1'b0);
    chk("resync_err", load_error, 1'b0);
    for (int i = 1; i <= 5; i++) send_byte(q[i]);
    @(negedge clk);
    chk("coll_pre", rom_data, 32'h44332211);
    @(posedge clk);
    @(negedge clk);
    chk("coll_same", rom_data, 32'h44332211);
    @(posedge clk);
    @(negedge clk);
    chk("coll_post", rom_data, 32'hDDCCBBAA);
    send_byte(q[6]);
    status_chk("l0");
    read_chk(0);
    read_chk(1);
    // Same spec frame with rx_valid toggling.
    make_frame(8'd1, seq(8'h11, 8'h11, 8), 8'd0);
    send_frame(1);
    read_chk(0);
    read_chk(1);
    make_frame(8'd1, rnd_bytes(8), 8'd0);
    send_frame(2);
    read_chk(0);
    read_chk(1);
    // Reset after the sixth data byte of the spec frame.
    send_byte(8'h5C);
    send_byte(8'h01);
    for (int i = 0; i < 6; i++) send_byte(u8'(8'h11 * (i + 1)));
    mdl[0] = 32'h44332211;
    #2 reset = 0;
    #1;
    chk("mid_cpu", cpu_reset, 1'b1);
    chk("mid_done", load_done, 1'b0);
    chk("mid_err", load_error, 1'b0);
    chk("mid_ready", rx_ready, 1'b0);
    chk("mid_rom", rom_data, 32'h0);
    @(negedge clk);
    reset = 1;
    exp_done = 0;
    exp_err  = 0;
    exp_cpu  = 1;
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h64);
    status_chk("post_rst");
    read_chk(0);
    read_chk(1);
    // Full-memory load.
    make_frame(8'hFF, seq(8'h01, 8'h00, 1024), 8'd0);
    send_frame(0);
    for (int a = 0; a < 256; a++) read_chk(a);
    // Randomized frames with junk, gaps and occasional bad checksums.
    repeat (8) begin
      repeat ($urandom_range(0, 3)) begin
        u8 b = u8'($urandom);
        send_byte(b == 8'h5C ? 8'h5D : b);
      end
      status_chk("garbage");
      begin
        u8 len   = u8'($urandom_range(0, 15));
        u8 delta = $urandom_range(0, 2) == 0 ? u8'($urandom_range(1, 255)) : 8'd0;
        make_frame(len, rnd_bytes(4 * (int'(len) + 1)), delta);
        send_frame($urandom_range(0, 2));
        for (int w = 0; w <= int'(len); w++) read_chk(w);
      end
      repeat (3) read_chk($urandom_range(0, 255));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sc1_loader.md
SC1_LOADER -- requirements
Module: sc1_loader

Interface
REQ-001 SHALL have parameter WIDTH_I, default 32, instruction word width in bits; only 32 is supported.
REQ-002 SHALL have parameter DEPTH_I, default 8, instruction address width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rx_data, input, 8 bits: loader byte stream.
REQ-006 SHALL have port rx_valid, input, 1 bit: rx_data is valid.
REQ-007 SHALL have port rx_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-008 SHALL have port rom_addr, input, DEPTH_I bits: CPU program-ROM read address.
REQ-009 SHALL have port rom_data, output, WIDTH_I bits: registered program word.
REQ-010 SHALL have port cpu_reset, output, 1 bit: active-high hold-in-reset for the downstream CPU.
REQ-011 SHALL have port load_done, output, 1 bit: last load was accepted.
REQ-012 SHALL have port load_error, output, 1 bit: last load failed its checksum.

Function
REQ-013 SHALL accept a byte only in a cycle where rx_valid and rx_ready are both 1.
REQ-014 SHALL hold rx_ready at 1 whenever reset is deasserted and at 0 while reset is asserted.
REQ-015 SHALL use the frame format: sync byte 0x5C, length byte L, 4*(L+1) data bytes, one checksum byte.
REQ-016 SHALL implement FSM states IDLE, LEN, DATA, CSUM, DONE, ERROR.
REQ-017 IDLE: SHALL discard non-sync bytes and move to LEN on 0x5C.
REQ-018 LEN: SHALL latch L, clear the word address, byte counter and checksum, then move to DATA.
REQ-019 DATA: SHALL assemble bytes little-endian (first byte goes to [7:0]).
REQ-020 DATA: SHALL write each complete word to RAM at the word address in the cycle after its 4th byte is accepted.
REQ-021 DATA: SHALL increment the word address modulo 2^DEPTH_I after each word write.
REQ-022 DATA: SHALL move to CSUM after word L has been assembled.
REQ-023 SHALL compute the checksum as the 8-bit modular sum of all data bytes only.
REQ-024 CSUM: SHALL move to DONE if the received byte equals the computed sum, otherwise to ERROR.
REQ-025 DONE: SHALL drive load_done=1, load_error=0 and cpu_reset=0, with all three registered and taking effect the cycle after the checksum byte is accepted.
REQ-026 ERROR: SHALL drive load_error=1, load_done=0 and cpu_reset=1.
REQ-027 DONE and ERROR: SHALL ignore non-sync bytes.
REQ-028 DONE and ERROR: a 0x5C byte SHALL move the FSM to LEN and, the next cycle, set cpu_reset=1, load_done=0 and load_error=0.
REQ-029 SHALL hold cpu_reset at 1 in IDLE, LEN, DATA and CSUM.
REQ-030 SHALL give rom_data one-cycle latency: rom_data = RAM[rom_addr] sampled at the previous clock edge.
REQ-031 SHALL leave words not written by the current load at their prior contents; the RAM is never cleared.
REQ-032 SHALL, when rom_addr equals the word being written in the same cycle, return the old contents on rom_data.
REQ-033 SHALL handle L=0xFF with DEPTH_I=8 (256 words) as a full-memory load with no error.
REQ-034 SHALL handle L+1 greater than 2^DEPTH_I by wrapping the address and overwriting earlier words, with no error.

Reset
REQ-035 On reset assertion the FSM SHALL go to IDLE asynchronously, including mid-frame.
REQ-036 On reset assertion the outputs SHALL go to cpu_reset=1, load_done=0, load_error=0, rx_ready=0 and rom_data=0.
REQ-037 On reset assertion the byte counter, word address, latched L and checksum SHALL go to 0.
REQ-038 Reset SHALL NOT clear RAM contents.

Structure
REQ-039 A shared package sc1_loader_pkg SHALL hold the SYNC_BYTE=0x5C constant and the FSM state encoding.
REQ-040 The program RAM SHALL be one instance of the existing rw_port_ram sub-module, with DATA_WIDTH=WIDTH_I and ADDR_WIDTH=DEPTH_I.
REQ-041 All other logic (FSM, assembler, checksum, status flags) SHALL be in sc1_loader itself.

Verification
REQ-042 Bytes 00 FF 5C 01 11 22 33 44 55 66 77 88 64 -> load_done=1 and cpu_reset=0; rom_addr=0 gives rom_data=0x44332211 one cycle later; rom_addr=1 gives 0x88776655.
REQ-043 The same frame with checksum 0x65 -> load_error=1, load_done=0, cpu_reset=1; a following correct frame -> load_done=1, load_error=0.
REQ-044 With rx_valid toggling 1/0 every cycle during the REQ-042 frame -> the same RAM contents and the same status result.
REQ-045 After DONE, send 0x5C -> cpu_reset=1 and load_done=0 one cycle later; a frame with L=0 and data AA BB CC DD -> word 0=0xDDCCBBAA, word 1 still 0x88776655.
REQ-046 Assert reset after the 6th data byte of the REQ-042 frame -> cpu_reset=1, load_done=0, FSM in IDLE; the RAM keeps its previously written words.
REQ-047 Send L=0xFF with 1024 bytes of value 0x01 and checksum 0x00 -> load_done=1, every word=0x01010101, no error.
